// File: rtl/dsp_mac_pipe_if.sv
// Sample/result bundle for dsp_mac_pipe: operands and per-sample control in, result out.
interface dsp_mac_pipe_if #(
    parameter int A_WIDTH     = 20,
    parameter int B_WIDTH     = 18,
    parameter int Z_WIDTH     = 38,
    parameter int SHIFT_WIDTH = 6
);
    // Valid-only streaming: in_valid qualifies every input field in the cycle it is
    // high, out_valid qualifies z/overflow; there is no ready, neither side stalls.
    logic                   in_valid;
    logic [A_WIDTH-1:0]     a;
    logic [B_WIDTH-1:0]     b;
    logic                   unsigned_a;
    logic                   unsigned_b;
    logic                   load_acc;
    logic                   subtract;
    logic [SHIFT_WIDTH-1:0] shift_right;
    logic                   round;
    logic                   saturate;
    logic                   out_valid;
    logic [Z_WIDTH-1:0]     z;
    logic                   overflow;
    logic [B_WIDTH-1:0]     dly_b;

    modport master (
        output in_valid, a, b, unsigned_a, unsigned_b, load_acc, subtract,
               shift_right, round, saturate,
        input  out_valid, z, overflow, dly_b
    );

    modport slave (
        input  in_valid, a, b, unsigned_a, unsigned_b, load_acc, subtract,
               shift_right, round, saturate,
        output out_valid, z, overflow, dly_b
    );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Pipelined multiply / multiply-accumulate: [I] -> P (product) -> C (accumulator) -> Z
// (shift, round, range check, saturate). Control bits travel alongside each sample.
module dsp_mac_pipe #(
    parameter int    A_WIDTH     = 20,
    parameter int    B_WIDTH     = 18,
    parameter int    Z_WIDTH     = 38,
    parameter int    SHIFT_WIDTH = 6,
    parameter int    INPUT_REG   = 0,
    parameter string MODE        = "MAC"
) (
    input logic           clk,
    input logic           reset,
    dsp_mac_pipe_if.slave bus
);
    localparam int AW = A_WIDTH + B_WIDTH + 2;
    localparam int EW = AW + 1;
    localparam int XW = AW + 2;
    localparam bit MULT_ONLY = (MODE == "MULTIPLY");

    typedef struct packed {
        logic                   ua;
        logic                   ub;
        logic                   load;
        logic                   sub;
        logic [SHIFT_WIDTH-1:0] sh;
        logic                   rnd;
        logic                   sat;
    } ctrl_t;

    typedef struct packed {
        logic                   ua;
        logic                   ub;
        logic [SHIFT_WIDTH-1:0] sh;
        logic                   rnd;
        logic                   sat;
    } zctrl_t;

    ctrl_t              in_ctrl;
    logic               i_valid;
    logic [A_WIDTH-1:0] i_a;
    logic [B_WIDTH-1:0] i_b;
    ctrl_t              i_ctrl;

    assign in_ctrl = {bus.unsigned_a, bus.unsigned_b, bus.load_acc, bus.subtract,
                      bus.shift_right, bus.round, bus.saturate};

    generate
        if (INPUT_REG != 0) begin : g_in_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    i_valid <= 1'b0;
                    i_a     <= '0;
                    i_b     <= '0;
                    i_ctrl  <= '0;
                end else begin
                    i_valid <= bus.in_valid;
                    i_a     <= bus.a;
                    i_b     <= bus.b;
                    i_ctrl  <= in_ctrl;
                end
            end
        end else begin : g_in_comb
            assign i_valid = bus.in_valid;
            assign i_a     = bus.a;
            assign i_b     = bus.b;
            assign i_ctrl  = in_ctrl;
        end
    endgenerate

    // Stage P: one extra bit per operand makes the product exact in AW bits.
    logic signed [A_WIDTH:0] a_ext;
    logic signed [B_WIDTH:0] b_ext;
    logic signed [AW-1:0]    prod;
    logic                    p_valid;
    logic signed [AW-1:0]    p_prod;
    ctrl_t                   p_ctrl;

    assign a_ext = {(i_ctrl.ua ? 1'b0 : i_a[A_WIDTH-1]), i_a};
    assign b_ext = {(i_ctrl.ub ? 1'b0 : i_b[B_WIDTH-1]), i_b};
    assign prod  = AW'(a_ext) * AW'(b_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid <= 1'b0;
            p_prod  <= '0;
            p_ctrl  <= '0;
        end else begin
            p_valid <= i_valid;
            if (i_valid) begin
                p_prod <= prod;
                p_ctrl <= i_ctrl;
            end
        end
    end

    // Stage C: bubbles leave the accumulator untouched.
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] acc_next;
    logic                 c_valid;
    zctrl_t               c_ctrl;

    always_comb begin
        acc_base = (p_ctrl.load || MULT_ONLY) ? '0 : acc;
        acc_next = p_ctrl.sub ? (acc_base - p_prod) : (acc_base + p_prod);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            c_valid <= 1'b0;
            c_ctrl  <= '0;
        end else begin
            c_valid <= p_valid;
            if (p_valid) begin
                acc    <= acc_next;
                c_ctrl <= {p_ctrl.ua, p_ctrl.ub, p_ctrl.sh, p_ctrl.rnd, p_ctrl.sat};
            end
        end
    end

    // Stage Z: one guard bit keeps acc + 2^(sh-1) from wrapping before the shift.
    logic [SHIFT_WIDTH-1:0] sh;
    logic signed [EW-1:0]   acc_x;
    logic signed [EW-1:0]   rnd_add;
    logic signed [EW-1:0]   shifted;
    logic signed [XW-1:0]   s_x;
    logic signed [XW-1:0]   hi_lim;
    logic signed [XW-1:0]   lo_lim;
    logic                   over_hi;
    logic                   over_lo;
    logic [Z_WIDTH-1:0]     z_next;

    always_comb begin
        sh      = c_ctrl.sh;
        acc_x   = EW'(acc);
        rnd_add = '0;
        if (c_ctrl.rnd && (sh != '0) && (int'(sh) <= AW)) begin
            rnd_add = EW'(1) << (sh - 1'b1);
        end
        // Rounding with a shift beyond the accumulator always lands on zero.
        if (c_ctrl.rnd && (int'(sh) > AW)) begin
            shifted = '0;
        end else begin
            shifted = (acc_x + rnd_add) >>> sh;
        end
        s_x = XW'(shifted);
        if (c_ctrl.ua && c_ctrl.ub) begin
            lo_lim = '0;
            hi_lim = (XW'(1) << Z_WIDTH) - XW'(1);
        end else begin
            lo_lim = -(XW'(1) << (Z_WIDTH - 1));
            hi_lim = (XW'(1) << (Z_WIDTH - 1)) - XW'(1);
        end
        over_hi = (s_x > hi_lim);
        over_lo = (s_x < lo_lim);
        if (c_ctrl.sat && over_hi) begin
            z_next = hi_lim[Z_WIDTH-1:0];
        end else if (c_ctrl.sat && over_lo) begin
            z_next = lo_lim[Z_WIDTH-1:0];
        end else begin
            z_next = shifted[Z_WIDTH-1:0];
        end
    end

    logic               z_valid;
    logic [Z_WIDTH-1:0] z_q;
    logic               ovf_q;
    logic [B_WIDTH-1:0] dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            z_valid <= 1'b0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
            dly_q   <= '0;
        end else begin
            z_valid <= c_valid;
            dly_q   <= bus.b;
            if (c_valid) begin
                z_q   <= z_next;
                ovf_q <= over_hi | over_lo;
            end
        end
    end

    assign bus.out_valid = z_valid;
    assign bus.z         = z_q;
    assign bus.overflow  = ovf_q;
    assign bus.dly_b     = dly_q;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a MAC instance (no input register) and a MULTIPLY instance
// (input register) share one stimulus stream and are scored against a longint model.
module tb_dsp_mac_pipe;
    localparam int AWD = 20;
    localparam int BWD = 18;
    localparam int ZWD = 38;
    localparam int SWD = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_mac_pipe_if #(.A_WIDTH(AWD), .B_WIDTH(BWD), .Z_WIDTH(ZWD), .SHIFT_WIDTH(SWD)) bus_m ();
    dsp_mac_pipe_if #(.A_WIDTH(AWD), .B_WIDTH(BWD), .Z_WIDTH(ZWD), .SHIFT_WIDTH(SWD)) bus_x ();

    dsp_mac_pipe #(.A_WIDTH(AWD), .B_WIDTH(BWD), .Z_WIDTH(ZWD), .SHIFT_WIDTH(SWD),
                   .INPUT_REG(0), .MODE("MAC")) dut_m (
        .clk(clk), .reset(reset), .bus(bus_m.slave));
    dsp_mac_pipe #(.A_WIDTH(AWD), .B_WIDTH(BWD), .Z_WIDTH(ZWD), .SHIFT_WIDTH(SWD),
                   .INPUT_REG(1), .MODE("MULTIPLY")) dut_x (
        .clk(clk), .reset(reset), .bus(bus_x.slave));

    assign bus_x.in_valid    = bus_m.in_valid;
    assign bus_x.a           = bus_m.a;
    assign bus_x.b           = bus_m.b;
    assign bus_x.unsigned_a  = bus_m.unsigned_a;
    assign bus_x.unsigned_b  = bus_m.unsigned_b;
    assign bus_x.load_acc    = bus_m.load_acc;
    assign bus_x.subtract    = bus_m.subtract;
    assign bus_x.shift_right = bus_m.shift_right;
    assign bus_x.round       = bus_m.round;
    assign bus_x.saturate    = bus_m.saturate;

    // ---------------- scoreboard state ----------------
    // Queue item: {due cycle[31:0], overflow, z[37:0]}
    logic [70:0]  exp_q[2][$];
    logic [38:0]  last_exp[2];
    int           checks = 0;
    int           errors = 0;
    longint       acc_m = 0;
    logic [17:0]  exp_dly = '0;
    bit           post_reset = 1'b0;

    // ---------------- reference model ----------------
    function automatic longint wrap_aw(input longint v);
        longint t;
        t = v <<< 24;
        return t >>> 24;
    endfunction

    function automatic longint opnd(input logic [31:0] raw, input int w, input bit uns);
        longint v;
        v = longint'(raw);
        if (!uns && raw[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic logic [70:0] result(input longint acc, input int sh, input bit rnd,
                                           input bit sat, input bit urange, input logic [31:0] due);
        longint s, lo, hi, zv;
        bit     ovf;
        if (rnd && sh > 0) s = (acc + (longint'(1) << (sh - 1))) >>> sh;
        else               s = acc >>> sh;
        if (urange) begin
            lo = 0;
            hi = (longint'(1) << ZWD) - 1;
        end else begin
            lo = -(longint'(1) << (ZWD - 1));
            hi = (longint'(1) << (ZWD - 1)) - 1;
        end
        ovf = (s < lo) || (s > hi);
        zv  = s;
        if (sat && s > hi) zv = hi;
        if (sat && s < lo) zv = lo;
        return {due, ovf, zv[ZWD-1:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_dly();
        chk("dly_b_mac", 64'(bus_m.dly_b), 64'(exp_dly));
        chk("dly_b_mul", 64'(bus_x.dly_b), 64'(exp_dly));
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input bit v, input logic [19:0] a, input logic [17:0] b,
                        input bit ua, input bit ub, input bit ld, input bit sb,
                        input logic [5:0] sh, input bit rnd, input bit sat,
                        input bit dir, input logic [37:0] dz, input bit dovf);
        longint      p;
        logic [70:0] it;
        @(negedge clk);
        check_dly();
        if (post_reset) begin
            chk("rst_out_valid_mac", 64'(bus_m.out_valid), 64'd0);
            chk("rst_z_mac",         64'(bus_m.z),         64'd0);
            chk("rst_overflow_mac",  64'(bus_m.overflow),  64'd0);
            chk("rst_out_valid_mul", 64'(bus_x.out_valid), 64'd0);
            chk("rst_z_mul",         64'(bus_x.z),         64'd0);
            post_reset = 1'b0;
        end
        reset                = 1'b0;
        bus_m.in_valid       = v;
        bus_m.a              = a;
        bus_m.b              = b;
        bus_m.unsigned_a     = ua;
        bus_m.unsigned_b     = ub;
        bus_m.load_acc       = ld;
        bus_m.subtract       = sb;
        bus_m.shift_right    = sh;
        bus_m.round          = rnd;
        bus_m.saturate       = sat;
        exp_dly              = b;
        if (v) begin
            p     = opnd(32'(a), AWD, ua) * opnd(32'(b), BWD, ub);
            acc_m = wrap_aw((ld ? longint'(0) : acc_m) + (sb ? -p : p));
            it    = result(acc_m, int'(sh), rnd, sat, ua && ub, 32'(cyc + 3));
            if (dir) it = {32'(cyc + 3), dovf, dz};
            exp_q[0].push_back(it);
            exp_q[1].push_back(result(wrap_aw(sb ? -p : p), int'(sh), rnd, sat, ua && ub,
                                      32'(cyc + 4)));
        end
    endtask

    task automatic idle();
        send(1'b0, 20'($urandom), 18'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0,
             1'b0, 38'd0, 1'b0);
    endtask

    task automatic go(input logic [19:0] a, input logic [17:0] b, input bit ua, input bit ub,
                      input bit ld, input bit sb, input logic [5:0] sh, input bit rnd,
                      input bit sat, input logic [37:0] dz, input bit dovf);
        send(1'b1, a, b, ua, ub, ld, sb, sh, rnd, sat, 1'b1, dz, dovf);
    endtask

    // A sample offered alongside reset must be dropped.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_dly();
            reset          = 1'b1;
            bus_m.in_valid = 1'b1;
            bus_m.a        = 20'($urandom);
            bus_m.b        = 18'($urandom);
            exp_q[0].delete();
            exp_q[1].delete();
            last_exp[0]    = '0;
            last_exp[1]    = '0;
            acc_m          = 0;
            exp_dly        = '0;
            post_reset     = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int k, input bit ov, input logic [37:0] zz, input bit of);
        logic [70:0] it;
        string       nm;
        nm = (k == 0) ? "mac_ir0" : "mul_ir1";
        if (ov) begin
            checks++;
            if (exp_q[k].size() == 0) begin
                errors++;
                $display("FAIL %s spurious out_valid at cycle %0d z=%h", nm, cyc, zz);
            end else begin
                it = exp_q[k].pop_front();
                last_exp[k] = it[38:0];
                if (it[70:39] != 32'(cyc) || zz !== it[37:0] || of !== it[38]) begin
                    errors++;
                    $display("FAIL %s result actual cycle=%0d z=%h ovf=%0b required cycle=%0d z=%h ovf=%0b",
                             nm, cyc, zz, of, it[70:39], it[37:0], it[38]);
                end
            end
        end else begin
            checks++;
            if (zz !== last_exp[k][37:0] || of !== last_exp[k][38]) begin
                errors++;
                $display("FAIL %s hold actual z=%h ovf=%0b required z=%h ovf=%0b",
                         nm, zz, of, last_exp[k][37:0], last_exp[k][38]);
            end
            if (exp_q[k].size() > 0) begin
                it = exp_q[k][0];
                if (it[70:39] <= 32'(cyc)) begin
                    checks++;
                    errors++;
                    $display("FAIL %s missing out_valid actual=0 required=1 at cycle %0d", nm, cyc);
                    void'(exp_q[k].pop_front());
                end
            end
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        mon(0, bus_m.out_valid, bus_m.z, bus_m.overflow);
        mon(1, bus_x.out_valid, bus_x.z, bus_x.overflow);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        last_exp[0]       = '0;
        last_exp[1]       = '0;
        reset             = 1'b1;
        bus_m.in_valid    = 1'b0;
        bus_m.a           = '0;
        bus_m.b           = '0;
        bus_m.unsigned_a  = 1'b0;
        bus_m.unsigned_b  = 1'b0;
        bus_m.load_acc    = 1'b0;
        bus_m.subtract    = 1'b0;
        bus_m.shift_right = '0;
        bus_m.round       = 1'b0;
        bus_m.saturate    = 1'b0;
        do_reset(2);

        // signed multiply: -3 * 5
        go(20'hFFFFD, 18'd5, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 38'h3F_FFFF_FFF1, 1'b0);
        repeat (4) idle();
        // MAC sequence with a gap: 6, (bubble), 26, 25
        go(20'd2, 18'd3, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 38'd6, 1'b0);
        idle();
        go(20'd4, 18'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 38'd26, 1'b0);
        go(20'd1, 18'd1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 38'd25, 1'b0);
        // unsigned corner and the same bits as signed (-1 * -1)
        go(20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 38'h3F_FFEC_0001, 1'b0);
        go(20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 38'd1, 1'b0);
        // shift / round: 23>>2 -> 6 / 5, -23>>2 -> -6 / -6
        go(20'd23, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 38'd6, 1'b0);
        go(20'd23, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 38'd5, 1'b0);
        go(20'hFFFE9, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 38'h3F_FFFF_FFFA, 1'b0);
        go(20'hFFFE9, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 38'h3F_FFFF_FFFA, 1'b0);
        // shift past the accumulator width: 0, -1, and 0 when rounding
        go(20'd5, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd45, 1'b0, 1'b0, 38'd0, 1'b0);
        go(20'hFFFFB, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd45, 1'b0, 1'b0, 38'h3F_FFFF_FFFF, 1'b0);
        go(20'hFFFFB, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd45, 1'b1, 1'b0, 38'd0, 1'b0);
        // (-2^19)*(-2^17) = 2^36 in range; accumulating it twice reaches 2^37 (over range)
        go(20'h80000, 18'h20000, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 38'h10_0000_0000, 1'b0);
        go(20'h80000, 18'h20000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 38'h1F_FFFF_FFFF, 1'b1);
        go(20'h80000, 18'h20000, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 38'h10_0000_0000, 1'b0);
        go(20'h80000, 18'h20000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 38'h20_0000_0000, 1'b1);
        // reset with three samples in flight, then accumulate onto a cleared acc
        go(20'd9, 18'd9, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 38'd81, 1'b0);
        go(20'd3, 18'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 38'd90, 1'b0);
        go(20'd2, 18'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 38'd94, 1'b0);
        do_reset(1);
        go(20'd7, 18'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 38'd7, 1'b0);
        repeat (5) idle();

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset(1);
            send(($urandom_range(0, 99) < 80), 20'($urandom), 18'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 20), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b0, 38'd0, 1'b0);
        end

        for (int i = 0; i < 10; i++) idle();
        chk("drain_mac", 64'(exp_q[0].size()), 64'd0);
        chk("drain_mul", 64'(exp_q[1].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
